// File: rtl/operand_forward_pipe.sv
`timescale 1ns/1ps
// operand_forward_pipe
//   ID->EX pipeline register and operand forwarding network for the
//   4-register core. Captures decoded operands, replaces stale register
//   file data with in-flight EX/MEM/WB results, raises the one-cycle
//   load-use stall, applies the branch flush and drives the RF write port.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   id_*                decoded instruction currently in ID
//   rf_a/b_data         register-file read data for id_ra/id_rb
//   br_clr              flush: ID instruction must not enter EX
//   ex_result           ALU result of the EX instruction (comb. from ex_a/ex_b)
//   mem_load_data       memory read data for the MEM instruction
//   ex_valid/ex_a/ex_b  registered EX operands, a_sel/b_sel their source
//                       (00 RF, 10 EX, 01 MEM, 11 WB)
//   stall               combinational load-use hold for PC/ID
//   wb_en/wb_rd/wb_data register-file write port

// Per-operand forward selector. A source that is not used never matches,
// so it takes RF data and can never cause a stall.
module ofp_fwd_mux #(
  parameter int DATA_W = 8
) (
  input  logic [1:0]        src,
  input  logic              used,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_live,
  input  logic [1:0]        ex_rd,
  input  logic [DATA_W-1:0] ex_val,
  input  logic              mem_live,
  input  logic [1:0]        mem_rd,
  input  logic [DATA_W-1:0] mem_val,
  input  logic              wb_live,
  input  logic [1:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_val,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] data,
  output logic              ex_hit
);
  logic ex_m, mem_m, wb_m;

  assign ex_m   = used & ex_live  & (ex_rd  == src);
  assign mem_m  = used & mem_live & (mem_rd == src);
  assign wb_m   = used & wb_live  & (wb_rd  == src);
  assign ex_hit = ex_m;

  // Youngest producer wins.
  always_comb begin
    sel  = 2'b00;
    data = rf_data;
    if (ex_m) begin
      sel  = 2'b10;
      data = ex_val;
    end else if (mem_m) begin
      sel  = 2'b01;
      data = mem_val;
    end else if (wb_m) begin
      sel  = 2'b11;
      data = wb_val;
    end
  end
endmodule

module operand_forward_pipe #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [1:0]        id_ra,
  input  logic [1:0]        id_rb,
  input  logic              id_ra_used,
  input  logic              id_rb_used,
  input  logic              id_wr,
  input  logic [1:0]        id_rd,
  input  logic              id_is_load,
  input  logic [DATA_W-1:0] rf_a_data,
  input  logic [DATA_W-1:0] rf_b_data,
  input  logic              br_clr,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] mem_load_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic              stall,
  output logic [1:0]        a_sel,
  output logic [1:0]        b_sel,
  output logic              wb_en,
  output logic [1:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data
);
  localparam int NOPND = 2;

  // EX stage state (valid/operands are ports)
  logic [1:0]        ex_rd;
  logic              ex_wr, ex_ld;
  // MEM stage state
  logic              mem_valid, mem_wr, mem_ld;
  logic [1:0]        mem_rd;
  logic [DATA_W-1:0] mem_alu, mem_val;

  // Operand lanes: index 0 = A, 1 = B
  logic [NOPND-1:0][1:0]        src;
  logic [NOPND-1:0]             used;
  logic [NOPND-1:0][DATA_W-1:0] rf_data;
  logic [NOPND-1:0][1:0]        fwd_sel;
  logic [NOPND-1:0][DATA_W-1:0] fwd_data;
  logic [NOPND-1:0]             ex_hit;
  logic                         bubble;

  assign src     = {id_rb, id_ra};
  assign used    = {id_rb_used, id_ra_used};
  assign rf_data = {rf_b_data, rf_a_data};

  assign mem_val = mem_ld ? mem_load_data : mem_alu;

  generate
    for (genvar i = 0; i < NOPND; i++) begin : g_opnd
      ofp_fwd_mux #(.DATA_W(DATA_W)) u_mux (
        .src      (src[i]),
        .used     (used[i]),
        .rf_data  (rf_data[i]),
        .ex_live  (ex_valid & ex_wr),
        .ex_rd    (ex_rd),
        .ex_val   (ex_result),
        .mem_live (mem_valid & mem_wr),
        .mem_rd   (mem_rd),
        .mem_val  (mem_val),
        .wb_live  (wb_en),
        .wb_rd    (wb_rd),
        .wb_val   (wb_data),
        .sel      (fwd_sel[i]),
        .data     (fwd_data[i]),
        .ex_hit   (ex_hit[i])
      );
    end
  endgenerate

  // A load in EX has no data yet; a used source hitting it must wait one
  // cycle so the value can be taken from MEM. Flush suppresses the stall.
  assign stall  = id_valid & ~br_clr & ex_valid & ex_ld & (|ex_hit);
  assign bubble = br_clr | stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_wr     <= 1'b0;
      ex_ld     <= 1'b0;
      ex_rd     <= '0;
      ex_a      <= '0;
      ex_b      <= '0;
      a_sel     <= '0;
      b_sel     <= '0;
      mem_valid <= 1'b0;
      mem_wr    <= 1'b0;
      mem_ld    <= 1'b0;
      mem_rd    <= '0;
      mem_alu   <= '0;
      wb_en     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
    end else begin
      if (bubble) begin
        ex_valid <= 1'b0;
        ex_wr    <= 1'b0;
        ex_ld    <= 1'b0;
        ex_rd    <= '0;
        ex_a     <= '0;
        ex_b     <= '0;
        a_sel    <= '0;
        b_sel    <= '0;
      end else begin
        ex_valid <= id_valid;
        ex_wr    <= id_wr;
        ex_ld    <= id_is_load;
        ex_rd    <= id_rd;
        ex_a     <= fwd_data[0];
        ex_b     <= fwd_data[1];
        a_sel    <= fwd_sel[0];
        b_sel    <= fwd_sel[1];
      end
      // MEM and WB always advance, including during a stall.
      mem_valid <= ex_valid;
      mem_wr    <= ex_wr;
      mem_ld    <= ex_ld;
      mem_rd    <= ex_rd;
      mem_alu   <= ex_result;
      wb_en     <= mem_valid & mem_wr;
      wb_rd     <= mem_rd;
      wb_data   <= mem_val;
    end
  end
endmodule

// File: tb/tb_operand_forward_pipe.sv
`timescale 1ns/1ps
module tb_operand_forward_pipe;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid, id_ra_used, id_rb_used, id_wr, id_is_load, br_clr;
  logic [1:0]        id_ra, id_rb, id_rd;
  logic [DATA_W-1:0] rf_a_data, rf_b_data, ex_result, mem_load_data;
  logic              ex_valid, stall, wb_en;
  logic [DATA_W-1:0] ex_a, ex_b, wb_data;
  logic [1:0]        a_sel, b_sel, wb_rd;

  operand_forward_pipe #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_ra_used(id_ra_used), .id_rb_used(id_rb_used), .id_wr(id_wr),
    .id_rd(id_rd), .id_is_load(id_is_load), .rf_a_data(rf_a_data),
    .rf_b_data(rf_b_data), .br_clr(br_clr), .ex_result(ex_result),
    .mem_load_data(mem_load_data), .ex_valid(ex_valid), .ex_a(ex_a),
    .ex_b(ex_b), .stall(stall), .a_sel(a_sel), .b_sel(b_sel),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] a, b;
    logic [1:0]        asel, bsel;
  } ex_exp_t;
  typedef struct packed {
    logic [1:0]        rd;
    logic [DATA_W-1:0] data;
  } wb_exp_t;

  ex_exp_t ex_q[$];
  wb_exp_t wb_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_ex(input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] asel, input logic [1:0] bsel);
    ex_exp_t e;
    e.a = a; e.b = b; e.asel = asel; e.bsel = bsel;
    ex_q.push_back(e);
  endtask

  task automatic push_wb(input logic [1:0] rd, input logic [7:0] data);
    wb_exp_t w;
    w.rd = rd; w.data = data;
    wb_q.push_back(w);
  endtask

  // Advance one cycle and return ID/EX/MEM inputs to idle defaults.
  task automatic tick();
    @(posedge clk); #1;
    id_valid = 0; id_wr = 0; id_rd = 0; id_is_load = 0;
    id_ra = 0; id_rb = 0; id_ra_used = 0; id_rb_used = 0;
    rf_a_data = 0; rf_b_data = 0; br_clr = 0;
    ex_result = 0; mem_load_data = 0;
  endtask

  task automatic op(input logic v, input logic wr, input logic [1:0] rd, input logic ld,
                    input logic [1:0] ra, input logic rau, input logic [7:0] rfa,
                    input logic [1:0] rb, input logic rbu, input logic [7:0] rfb);
    id_valid = v; id_wr = wr; id_rd = rd; id_is_load = ld;
    id_ra = ra; id_ra_used = rau; rf_a_data = rfa;
    id_rb = rb; id_rb_used = rbu; rf_b_data = rfb;
  endtask

  // Scoreboard monitor: every real EX capture and every RF write must match
  // the next expectation pushed when the instruction was issued.
  always @(negedge clk) begin
    ex_exp_t e;
    wb_exp_t w;
    if (ex_valid === 1'b1) begin
      if (ex_q.size() == 0) chk("ex_extra", 1, 0);
      else begin
        e = ex_q.pop_front();
        chk("ex_a", ex_a, e.a);
        chk("ex_b", ex_b, e.b);
        chk("a_sel", a_sel, e.asel);
        chk("b_sel", b_sel, e.bsel);
      end
    end
    if (wb_en === 1'b1) begin
      if (wb_q.size() == 0) chk("wb_extra", 1, 0);
      else begin
        w = wb_q.pop_front();
        chk("wb_rd", wb_rd, w.rd);
        chk("wb_data", wb_data, w.data);
      end
    end
  end

  initial begin
    rst = 1;
    op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    br_clr = 0; ex_result = 0; mem_load_data = 0;

    // Reset held with a live instruction in ID
    for (int i = 0; i < 3; i++) begin
      tick();
      op(1, 1, 1, 0, 1, 1, 8'h99, 2, 1, 8'h55);
      #1;
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_wb_en", wb_en, 0);
      chk("rst_stall", stall, 0);
      chk("rst_ex_a", ex_a, 0);
      chk("rst_a_sel", a_sel, 0);
    end

    // C0: I1 r1 <- r2 op r3
    tick(); rst = 0;
    op(1, 1, 1, 0, 2, 1, 8'h03, 3, 1, 8'h02);
    push_ex(8'h03, 8'h02, 2'b00, 2'b00); push_wb(1, 8'h05);
    // C1: I2 reads r1 at distance 1
    tick(); ex_result = 8'h05;
    op(1, 1, 2, 0, 1, 1, 8'hEE, 0, 0, 8'h44);
    push_ex(8'h05, 8'h44, 2'b10, 2'b00); push_wb(2, 8'h0C);
    #1 chk("alu_chain_stall", stall, 0);
    // C2
    tick(); ex_result = 8'h0C;
    #1 chk("lat_wb_early", wb_en, 0);
    // C3: first write appears 3 edges after reset release
    tick();
    #1 chk("lat_wb_en", wb_en, 1);
    tick();                                               // C4

    // C5: load r2
    tick();
    op(1, 1, 2, 1, 0, 0, 8'h10, 0, 0, 8'h20);
    push_ex(8'h10, 8'h20, 2'b00, 2'b00); push_wb(2, 8'hA5);
    // C6: consumer reads rb=2 -> stall
    tick(); ex_result = 8'h77;
    op(1, 1, 3, 0, 0, 1, 8'h01, 2, 1, 8'h5A);
    #1 chk("lu_stall", stall, 1);
    // C7: same consumer re-presented, load now in MEM
    tick(); mem_load_data = 8'hA5;
    op(1, 1, 3, 0, 0, 1, 8'h01, 2, 1, 8'h5A);
    push_ex(8'h01, 8'hA5, 2'b00, 2'b01); push_wb(3, 8'h33);
    #1;
    chk("lu_bubble", ex_valid, 0);
    chk("lu_stall_once", stall, 0);
    tick(); ex_result = 8'h33;                            // C8
    tick(); tick();                                       // C9, C10

    // Priority: P1/P2/P3 all write r3
    tick(); op(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);             // C11
    push_ex(0, 0, 2'b00, 2'b00); push_wb(3, 8'h11);
    tick(); ex_result = 8'h11; op(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);  // C12
    push_ex(0, 0, 2'b00, 2'b00); push_wb(3, 8'h22);
    tick(); ex_result = 8'h22; op(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);  // C13
    push_ex(0, 0, 2'b00, 2'b00); push_wb(3, 8'h33);
    tick(); ex_result = 8'h33; mem_load_data = 8'hEE;     // C14: ra==rb==3
    op(1, 0, 0, 0, 3, 1, 8'hF0, 3, 1, 8'hF0);
    push_ex(8'h33, 8'h33, 2'b10, 2'b10);
    #1 chk("prio_stall", stall, 0);

    // Priority again, EX instruction does not write
    tick(); op(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);             // C15
    push_ex(0, 0, 2'b00, 2'b00); push_wb(3, 8'h11);
    tick(); ex_result = 8'h11; op(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);  // C16
    push_ex(0, 0, 2'b00, 2'b00); push_wb(3, 8'h22);
    tick(); ex_result = 8'h22; op(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);  // C17
    push_ex(0, 0, 2'b00, 2'b00);
    tick(); ex_result = 8'h99;                            // C18
    op(1, 0, 0, 0, 3, 1, 8'hF0, 3, 0, 8'h4D);
    push_ex(8'h22, 8'h4D, 2'b01, 2'b00);

    // Distance 3: WB forward
    tick(); op(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);             // C19
    push_ex(0, 0, 2'b00, 2'b00); push_wb(1, 8'h5C);
    tick(); ex_result = 8'h5C;                            // C20
    tick();                                               // C21
    tick(); op(1, 0, 0, 0, 1, 1, 8'h0F, 0, 0, 0);         // C22
    push_ex(8'h5C, 0, 2'b11, 2'b00);

    // Flush against a load-use condition
    tick(); op(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);             // C23
    push_ex(0, 0, 2'b00, 2'b00); push_wb(1, 8'hC3);
    tick(); br_clr = 1;                                   // C24
    op(1, 1, 2, 0, 1, 1, 8'h00, 0, 0, 0);
    #1 chk("flush_stall", stall, 0);
    tick(); mem_load_data = 8'hC3;                        // C25
    #1 chk("flush_bubble", ex_valid, 0);
    tick();                                               // C26

    // Unused source matching an EX load
    tick(); op(1, 1, 2, 1, 0, 0, 0, 0, 0, 0);             // C27
    push_ex(0, 0, 2'b00, 2'b00); push_wb(2, 8'h3C);
    tick(); op(1, 0, 0, 0, 0, 1, 8'h12, 2, 0, 8'h6B);     // C28
    push_ex(8'h12, 8'h6B, 2'b00, 2'b00);
    #1 chk("unused_stall", stall, 0);
    tick(); mem_load_data = 8'h3C;                        // C29
    tick(); tick();                                       // C30, C31

    // Reset mid-stream: X and Y must never write
    tick(); op(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);             // C32
    push_ex(0, 0, 2'b00, 2'b00);
    tick(); ex_result = 8'h42; op(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);  // C33
    push_ex(0, 0, 2'b00, 2'b00);
    tick(); rst = 1; ex_result = 8'h43;                   // C34
    tick();                                               // C35
    #1;
    chk("mrst_ex_valid", ex_valid, 0);
    chk("mrst_wb_en", wb_en, 0);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1 chk("mrst_no_write", wb_en, 0);
    end

    chk("ex_q_left", ex_q.size(), 0);
    chk("wb_q_left", wb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/operand_forward_pipe.md
# operand_forward_pipe

Pipeline-register and forwarding datapath that sits between the ID stage and the ALU of the 4-register pipelined core. It captures decoded operands each cycle and replaces stale register-file data with in-flight EX/MEM/WB results. It also generates the one-cycle load-use stall and applies the branch flush. It carries destination tags with valid bits through EX, MEM and WB, and drives the register-file write port.

## Interface
- DATA_W, 8, operand/result width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_ra, id_rb  in  2 each  source register addresses
- id_ra_used, id_rb_used  in  1 each  source actually read by the instruction
- id_wr  in  1  instruction writes a register
- id_rd  in  2  destination register
- id_is_load  in  1  instruction is a load (result available in MEM)
- rf_a_data, rf_b_data  in  DATA_W each  register-file read data for id_ra/id_rb
- br_clr  in  1  flush: instruction in ID must not enter EX
- ex_result  in  DATA_W  ALU result of the current EX instruction (combinational from ex_a/ex_b)
- mem_load_data  in  DATA_W  memory read data for the current MEM instruction
- ex_valid  out  1  EX holds a real instruction
- ex_a, ex_b  out  DATA_W each  registered, forwarded ALU operands
- stall  out  1  combinational; hold PC and ID this cycle
- a_sel, b_sel  out  2 each  registered forward source used for ex_a/ex_b: 00 RF, 10 EX, 01 MEM, 11 WB
- wb_en  out  1  register-file write enable
- wb_rd  out  2  write address
- wb_data  out  DATA_W  write data

## Operation
- **Stage state:**
  - EX: valid, rd, wr, is_load, a, b.
  - MEM: valid, rd, wr, is_load, alu (captured from ex_result).
  - WB: wb_en, wb_rd, wb_data.
- **MEM value:** mem_is_load ? mem_load_data : mem_alu.
- **Match rule:** a stage matches source s when stage valid & stage wr & stage rd == s. All four registers are real; there is no hardwired zero register.
- **Forward priority per operand:** EX match → ex_result (sel 10); else MEM match → MEM value (01); else WB match → wb_data (11); else rf data (00).
- **Source gating:** an unused source (id_x_used=0) always takes sel 00 and never causes a stall.
- **Load-use stall:** stall = id_valid & !br_clr & EX valid & EX is_load & EX rd matches a used ID source.
- **During stall:**
  - EX loads a bubble (valid=0, wr=0, a/b/sel = 0).
  - MEM and WB advance normally.
  - The ID inputs are presented again next cycle.
- **Flush:** br_clr=1 → EX loads a bubble and stall is forced to 0. Flush has priority over stall.
- **Normal advance:**
  - EX ← ID fields, with valid = id_valid.
  - MEM ← EX fields.
  - WB ← wb_en = MEM valid & MEM wr, wb_rd = MEM rd, wb_data = MEM value.
- A bubble in MEM produces wb_en=0. wb_rd/wb_data still update but are don't-care to the register file.

## Timing
- **Reset:**
  - Every valid, wr and wb_en = 0; ex_a, ex_b, wb_data, wb_rd, a_sel, b_sel = 0.
  - stall = 0 (follows from EX valid = 0).
  - Reset asserted mid-stream discards all in-flight instructions at the next edge; no write issues afterward.
- **Latency:** ID → EX 1 cycle; EX → MEM 1; MEM → WB 1; wb_en asserted in the cycle after the MEM cycle.
- **Dependent distance 1 (non-load):** producer in EX at cycle t, consumer in ID at t → consumer's ex_a = ex_result at t, sel 10, no stall.
- **Dependent distance 1 (load):** stall=1 for exactly cycle t. At t+1 the load is in MEM, and the consumer captures mem_load_data with sel 01.
- **Distance 3:** producer in WB while consumer in ID → sel 11. The register file does not need write-through.
- **Simultaneous matches:** youngest wins (EX > MEM > WB).
- **Dual-source:** ra == rb resolves both operands identically.
- **br_clr + stall condition in same cycle:** stall=0, bubble inserted.
- **A load can stall only one cycle;** a second consecutive stall for the same pair cannot occur.

## Test plan
- Reset: hold rst 3 cycles with id_valid=1 → ex_valid=0, wb_en=0, stall=0, ex_a=0 throughout; first real instruction reaches wb_en 3 cycles after rst drops.
- Back-to-back ALU chain: r1←5 (ex_result=5), then add using ra=1 at the next cycle → ex_a=5, a_sel=10, no stall.
- Load-use: load r2 (mem_load_data=0xA5), next instruction reads rb=2 → stall=1 for one cycle, an EX bubble, then ex_b=0xA5 with b_sel=01.
- Priority: writes to r3 in WB (0x11), MEM (0x22) and EX (0x33) simultaneously, consumer reads r3 → ex_a=0x33, sel 10. Repeat with the EX instruction having wr=0 → 0x22, sel 01.
- Flush: br_clr=1 in the same cycle as a load-use condition → stall=0, ex_valid=0 next cycle, no wb_en for the flushed instruction.
- Unused source: id_rb_used=0, rb matches an EX load → no stall, b_sel=00.
